cm_piso: RTL and testbench

//  Parallel-in/serial-out shift register: the transmit-side counterpart of the delay/deserialize

---
 rtl/cm_piso.sv | 143 ++++++++++++++
 tb/tb_cm_piso.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cm_piso.sv
`default_nettype none
// ============================================================================
// Module   : cm_piso
// Purpose  : Parallel-in / serial-out shift register. Accepts one DATA_W
//            word over a valid/ready handshake and emits it as
//            NBEAT = DATA_W/SER_W beats of SER_W bits over a downstream
//            valid/ready handshake. Back-to-back words stream with no
//            bubble: the next word is accepted in the cycle its
//            predecessor's last beat is taken.
// Params   : DATA_W    - parallel word width (multiple of SER_W)
//            SER_W     - beat width
//            MSB_FIRST - 1: beat 0 is the top SER_W bits; 0: bottom bits
// Ports    : i_clk, i_rst  - clock, asynchronous active-high reset
//            i_valid/o_ready/i_data         - parallel input handshake
//            o_valid/i_ready/o_data         - serial output handshake
//            o_first/o_last                 - beat 0 / beat NBEAT-1 flags
//            o_beat (CM_PISO_BEAT_IDX_EN)   - index of the current beat
// Config   : define CM_PISO_BEAT_IDX_EN to add the o_beat output port.
// Revision : 1.0 - initial release
// ============================================================================
module cm_piso #(
   parameter int DATA_W    = 32,
   parameter int SER_W     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [SER_W-1:0]  o_data,
   output logic              o_first,
   output logic              o_last
`ifdef CM_PISO_BEAT_IDX_EN
   ,
   output logic [(((DATA_W/SER_W) > 1) ? $clog2(DATA_W/SER_W) : 1)-1:0] o_beat
`endif
);

   localparam int C_NBEAT = DATA_W / SER_W;
   localparam int C_CNT_W = (C_NBEAT > 1) ? $clog2(C_NBEAT) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_NBEAT - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

   // Reject configurations where the word does not split into whole beats.
   generate
      if ((SER_W < 1) || (DATA_W < SER_W) || ((DATA_W % SER_W) != 0)) begin : g_bad_width
         $error("cm_piso: DATA_W must be a non-zero multiple of SER_W");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [C_CNT_W-1:0]   w_cnt_nxt;
   logic [DATA_W-1:0]    r_shift;
   logic [DATA_W-1:0]    w_shift_nxt;
   logic [DATA_W-1:0]    w_shift_adv;
   logic                 w_last;
   logic                 w_ready;
   logic                 w_accept;

   // The beat on the wire always sits at the output end of the shift
   // register; advancing moves the next beat into that slot.
   generate
      if (C_NBEAT > 1) begin : g_multi
         if (MSB_FIRST != 0) begin : g_msb
            assign w_shift_adv = {r_shift[DATA_W-SER_W-1:0], {SER_W{1'b0}}};
         end else begin : g_lsb
            assign w_shift_adv = {{SER_W{1'b0}}, r_shift[DATA_W-1:SER_W]};
         end
      end else begin : g_single
         // Single-beat words never advance; the value is never selected.
         assign w_shift_adv = r_shift;
      end

      if (MSB_FIRST != 0) begin : g_out_msb
         assign o_data = r_shift[DATA_W-1 -: SER_W];
      end else begin : g_out_lsb
         assign o_data = r_shift[SER_W-1:0];
      end
   endgenerate

   assign w_last  = (r_state == ST_SHIFT) && (r_cnt == C_CNT_LAST);
   assign o_valid = (r_state == ST_SHIFT);
   assign o_first = (r_state == ST_SHIFT) && (r_cnt == '0);
   assign o_last  = w_last;
   assign o_ready = w_ready;

`ifdef CM_PISO_BEAT_IDX_EN
   assign o_beat = r_cnt;
`endif

   // Next-state / datapath logic. A beat transfer is evaluated first and a
   // simultaneous accept overrides it, so the final beat of one word and
   // the load of the next happen on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      // Ready depends only on state and downstream ready, never on i_valid.
      w_ready     = (r_state == ST_IDLE) || (w_last && i_ready);
      w_accept    = i_valid && w_ready;

      if ((r_state == ST_SHIFT) && i_ready) begin
         if (!w_last) begin
            w_shift_nxt = w_shift_adv;
            w_cnt_nxt   = r_cnt + C_CNT_ONE;
         end else begin
            // Shift register is left untouched so o_data holds its last beat.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      end

      if (w_accept) begin
         w_shift_nxt = i_data;
         w_cnt_nxt   = '0;
         w_state_nxt = ST_SHIFT;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cm_piso.sv
`default_nettype none
// ============================================================================
// Module   : tb_cm_piso
// Purpose  : Directed self-checking bench for cm_piso. Three instances:
//            32/8 MSB-first, 32/8 LSB-first (sharing stimulus) and 8/8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cm_piso;

   logic        clk = 1'b0;
   logic        rst;

   // Shared stimulus for the two 32-bit instances
   logic        a_valid;
   logic [31:0] a_data;
   logic        a_rdy;

   logic        ra_ready, ra_valid, ra_first, ra_last;
   logic [7:0]  ra_data;
   logic        rb_ready, rb_valid, rb_first, rb_last;
   logic [7:0]  rb_data;

   // Stimulus for the single-beat instance
   logic        c_valid;
   logic [7:0]  c_data;
   logic        c_rdy;
   logic        rc_ready, rc_valid, rc_first, rc_last;
   logic [7:0]  rc_data;

`ifdef CM_PISO_BEAT_IDX_EN
   logic [1:0]  ra_beat;
   logic [1:0]  rb_beat;
   logic [0:0]  rc_beat;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cm_piso #(.DATA_W(32), .SER_W(8), .MSB_FIRST(1)) u_dut_msb (
      .i_clk(clk), .i_rst(rst),
      .i_valid(a_valid), .o_ready(ra_ready), .i_data(a_data),
      .o_valid(ra_valid), .i_ready(a_rdy), .o_data(ra_data),
      .o_first(ra_first), .o_last(ra_last)
`ifdef CM_PISO_BEAT_IDX_EN
      , .o_beat(ra_beat)
`endif
   );

   cm_piso #(.DATA_W(32), .SER_W(8), .MSB_FIRST(0)) u_dut_lsb (
      .i_clk(clk), .i_rst(rst),
      .i_valid(a_valid), .o_ready(rb_ready), .i_data(a_data),
      .o_valid(rb_valid), .i_ready(a_rdy), .o_data(rb_data),
      .o_first(rb_first), .o_last(rb_last)
`ifdef CM_PISO_BEAT_IDX_EN
      , .o_beat(rb_beat)
`endif
   );

   cm_piso #(.DATA_W(8), .SER_W(8), .MSB_FIRST(1)) u_dut_one (
      .i_clk(clk), .i_rst(rst),
      .i_valid(c_valid), .o_ready(rc_ready), .i_data(c_data),
      .o_valid(rc_valid), .i_ready(c_rdy), .o_data(rc_data),
      .o_first(rc_first), .o_last(rc_last)
`ifdef CM_PISO_BEAT_IDX_EN
      , .o_beat(rc_beat)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_w [4];
   logic [7:0] exp_s [8];
   logic [7:0] exp_l [8];
   int         idx;

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_data = '0; a_rdy = 1'b0;
      c_valid = 1'b0; c_data = '0; c_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // ---------------- reset state ----------------
      chk("rst_valid", {31'd0, ra_valid}, 32'd0);
      chk("rst_data",  {24'd0, ra_data},  32'd0);
      chk("rst_first", {31'd0, ra_first}, 32'd0);
      chk("rst_last",  {31'd0, ra_last},  32'd0);
      chk("rst_ready", {31'd0, ra_ready}, 32'd1);
      rst = 1'b0;
      tick();
      chk("idle_ready", {31'd0, ra_ready}, 32'd1);

      // ---------------- test 1 / 2: single word, no backpressure ----------------
      exp_w[0] = 8'hA1; exp_w[1] = 8'hB2; exp_w[2] = 8'hC3; exp_w[3] = 8'hD4;
      a_valid = 1'b1; a_data = 32'hA1B2C3D4; a_rdy = 1'b1;
      chk("t1_acc_ready", {31'd0, ra_ready}, 32'd1);
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", {31'd0, ra_valid}, 32'd1);
         chk("t1_data",  {24'd0, ra_data},  {24'd0, exp_w[i]});
         chk("t1_first", {31'd0, ra_first}, {31'd0, (i == 0)});
         chk("t1_last",  {31'd0, ra_last},  {31'd0, (i == 3)});
         chk("t1_ready", {31'd0, ra_ready}, {31'd0, (i == 3)});
         chk("t2_data",  {24'd0, rb_data},  {24'd0, exp_w[3-i]});
         chk("t2_first", {31'd0, rb_first}, {31'd0, (i == 0)});
         chk("t2_last",  {31'd0, rb_last},  {31'd0, (i == 3)});
`ifdef CM_PISO_BEAT_IDX_EN
         chk("t1_beat",  {30'd0, ra_beat},  i);
`endif
         tick();
      end
      chk("t1_end_valid", {31'd0, ra_valid}, 32'd0);
      chk("t1_end_ready", {31'd0, ra_ready}, 32'd1);
`ifdef CM_PISO_BEAT_IDX_EN
      chk("t1_end_beat",  {30'd0, ra_beat},  32'd0);
`endif

      // ---------------- test 3: back-to-back words ----------------
      exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h33; exp_s[3] = 8'h44;
      exp_s[4] = 8'h55; exp_s[5] = 8'h66; exp_s[6] = 8'h77; exp_s[7] = 8'h88;
      exp_l[0] = 8'h44; exp_l[1] = 8'h33; exp_l[2] = 8'h22; exp_l[3] = 8'h11;
      exp_l[4] = 8'h88; exp_l[5] = 8'h77; exp_l[6] = 8'h66; exp_l[7] = 8'h55;
      a_valid = 1'b1; a_data = 32'h11223344;
      tick();
      a_data = 32'h55667788;
      for (int i = 0; i < 8; i++) begin
         chk("t3_valid", {31'd0, ra_valid}, 32'd1);
         chk("t3_data",  {24'd0, ra_data},  {24'd0, exp_s[i]});
         chk("t3_ldata", {24'd0, rb_data},  {24'd0, exp_l[i]});
         if (i < 4) begin
            chk("t3_ready", {31'd0, ra_ready}, {31'd0, (i == 3)});
         end
         tick();
         if (i == 3) a_valid = 1'b0;
      end
      chk("t3_end_valid", {31'd0, ra_valid}, 32'd0);

      // ---------------- test 4: downstream backpressure ----------------
      a_valid = 1'b1; a_data = 32'hA1B2C3D4; a_rdy = 1'b1;
      tick();
      a_valid = 1'b0;
      idx = 0;
      for (int k = 0; (k < 20) && (idx < 4); k++) begin
         a_rdy = ((k % 3) == 0);
         chk("t4_valid", {31'd0, ra_valid}, 32'd1);
         chk("t4_data",  {24'd0, ra_data},  {24'd0, exp_w[idx]});
         chk("t4_first", {31'd0, ra_first}, {31'd0, (idx == 0)});
         chk("t4_last",  {31'd0, ra_last},  {31'd0, (idx == 3)});
         tick();
         if (a_rdy) idx++;
      end
      a_rdy = 1'b1;
      chk("t4_handshakes", idx, 32'd4);
      chk("t4_end_valid", {31'd0, ra_valid}, 32'd0);

      // ---------------- test 5: asynchronous reset mid-word ----------------
      a_valid = 1'b1; a_data = 32'hDEADBEEF;
      tick();
      a_valid = 1'b0;
      chk("t5_beat0", {24'd0, ra_data}, 32'h0000_00DE);
      tick();
      chk("t5_beat1", {24'd0, ra_data}, 32'h0000_00AD);
      tick();
      chk("t5_beat2", {24'd0, ra_data}, 32'h0000_00BE);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_valid", {31'd0, ra_valid}, 32'd0);
      chk("t5_async_data",  {24'd0, ra_data},  32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_post_valid", {31'd0, ra_valid}, 32'd0);
         chk("t5_post_ready", {31'd0, ra_ready}, 32'd1);
      end

      // ---------------- test 6: single-beat configuration ----------------
      c_valid = 1'b1; c_data = 8'h5A; c_rdy = 1'b1;
      chk("t6_acc_ready", {31'd0, rc_ready}, 32'd1);
      tick();
      c_valid = 1'b0;
      chk("t6_valid", {31'd0, rc_valid}, 32'd1);
      chk("t6_data",  {24'd0, rc_data},  32'h0000_005A);
      chk("t6_first", {31'd0, rc_first}, 32'd1);
      chk("t6_last",  {31'd0, rc_last},  32'd1);
      chk("t6_ready", {31'd0, rc_ready}, 32'd1);
`ifdef CM_PISO_BEAT_IDX_EN
      chk("t6_beat",  {31'd0, rc_beat},  32'd0);
`endif
      tick();
      chk("t6_end_valid", {31'd0, rc_valid}, 32'd0);
      chk("t6_hold_data", {24'd0, rc_data},  32'h0000_005A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
